// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them
// to instruction memory at consecutive addresses, holding the core in reset until done.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {HDR0, HDR1, DATA, LAST, DONE, ERR} state_t;

  state_t      state;
  logic [15:0] count;
  logic [15:0] wordCnt;
  logic [1:0]  byteIdx;
  logic [23:0] shift;
  logic [15:0] hdrCount;
  logic        take;

  // load_start wins over a byte offered in the same cycle, so that byte is never consumed
  assign take     = in_valid && in_ready && !load_start;
  assign in_ready = rst_n && (state == HDR0 || state == HDR1 || state == DATA);
  assign hdrCount = {in_data, count[7:0]};

  // LAST covers the write-pulse cycle of the final word before the core is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HDR0;
      count     <= 16'd0;
      wordCnt   <= 16'd0;
      byteIdx   <= 2'd0;
      shift     <= 24'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (load_start) begin
        state    <= HDR0;
        count    <= 16'd0;
        wordCnt  <= 16'd0;
        byteIdx  <= 2'd0;
        shift    <= 24'd0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end else begin
        case (state)
          HDR0: begin
            if (take) begin
              count[7:0] <= in_data;
              state      <= HDR1;
            end
          end
          HDR1: begin
            if (take) begin
              count[15:8] <= in_data;
              if (hdrCount == 16'd0) begin
                state    <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else if (32'(hdrCount) > DEPTH) begin
                state <= ERR;
                err   <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (take) begin
              byteIdx <= byteIdx + 2'd1;
              if (byteIdx == 2'd3) begin
                mem_we    <= 1'b1;
                mem_wdata <= {in_data, shift};
                mem_addr  <= wordCnt[ADDR_W-1:0];
                wordCnt   <= wordCnt + 16'd1;
                if (wordCnt + 16'd1 == count) begin
                  state <= LAST;
                end
              end else begin
                shift <= {in_data, shift[23:8]};
              end
            end
          end
          LAST: begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
          DONE, ERR: begin
          end
          default: state <= HDR0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed byte streams checked against a
// reference model that decodes the image format straight into expected writes.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W+31:0] wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int          nCompared = 0;
  int          nMismatched = 0;
  wr_t         actQ[$];
  wr_t         expQ[$];
  logic [7:0]  strm[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && mem_we) actQ.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: header gives the word count; word i is bytes 2+4i..5+4i little-endian at address i
  task automatic buildExpected();
    int cnt;
    cnt = int'(strm[0]) + 256 * int'(strm[1]);
    if (cnt > DEPTH) return;
    for (int i = 0; i < cnt; i++) begin
      if (strm.size() >= 6 + 4 * i)
        expQ.push_back({ADDR_W'(i), strm[5+4*i], strm[4+4*i], strm[3+4*i], strm[2+4*i]});
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int validPct);
    bit acc;
    bit rdy;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < validPct) begin
        in_valid = 1'b1;
        in_data  = b;
        rdy      = in_ready;
        @(posedge clk);
        acc = rdy;
        #1 in_valid = 1'b0;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    if (!acc) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL byte_accept: got no transfer expected byte %h accepted", b);
    end
  endtask

  task automatic sendStream(input int validPct);
    foreach (strm[i]) sendByte(strm[i], validPct);
  endtask

  task automatic startTest();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    actQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset();
    #12;
    nCompared++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !==
        {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_values: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b expected 0 0 00 0 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nCompared++;
    if ({in_ready, cpu_hold, done} !== 3'b110) begin
      nMismatched++;
      $display("[TB] FAIL reset_release: got rdy/hold/done=%b%b%b expected 110", in_ready, cpu_hold, done);
    end
  endtask

  task automatic test_basic();
    startTest();
    strm = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00,
             8'h93, 8'h01, 8'h00, 8'h00};
    buildExpected();
    sendStream(100);
    @(negedge clk);
    nCompared++;
    if ({mem_we, mem_addr, mem_wdata, in_ready, done} !== {1'b1, 8'd2, 32'h00000193, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL basic_lastwrite: got we=%b a=%h d=%h rdy=%b done=%b expected 1 02 00000193 0 0",
               mem_we, mem_addr, mem_wdata, in_ready, done);
    end
    @(negedge clk);
    nCompared++;
    if ({done, cpu_hold, mem_we, in_ready, mem_addr} !== {4'b1000, 8'd2}) begin
      nMismatched++;
      $display("[TB] FAIL basic_done: got done=%b hold=%b we=%b rdy=%b a=%h expected 1 0 0 0 02",
               done, cpu_hold, mem_we, in_ready, mem_addr);
    end
    nCompared++;
    if (actQ.size() != expQ.size()) begin
      nMismatched++;
      $display("[TB] FAIL basic_nwrites: got %0d expected %0d", actQ.size(), expQ.size());
    end
    foreach (expQ[i]) if (i < actQ.size()) begin
      nCompared++;
      if (actQ[i] !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL basic_write%0d: got %h expected %h", i, actQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    startTest();
    strm = '{8'h00, 8'h00};
    sendStream(100);
    @(negedge clk);
    nCompared++;
    if ({done, in_ready, cpu_hold, err} !== 4'b1000) begin
      nMismatched++;
      $display("[TB] FAIL zero_done: got done=%b rdy=%b hold=%b err=%b expected 1 0 0 0",
               done, in_ready, cpu_hold, err);
    end
    repeat (3) @(negedge clk);
    nCompared++;
    if (actQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL zero_nwrites: got %0d expected 0", actQ.size());
    end
  endtask

  task automatic test_err();
    startTest();
    strm = '{8'h01, 8'h01};
    sendStream(100);
    @(negedge clk);
    nCompared++;
    if ({err, in_ready, cpu_hold, done} !== 4'b1010) begin
      nMismatched++;
      $display("[TB] FAIL err_flag: got err=%b rdy=%b hold=%b done=%b expected 1 0 1 0",
               err, in_ready, cpu_hold, done);
    end
    repeat (3) @(negedge clk);
    nCompared++;
    if (actQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL err_nwrites: got %0d expected 0", actQ.size());
    end
    startTest();
    nCompared++;
    if ({err, in_ready, cpu_hold, done} !== 4'b0110) begin
      nMismatched++;
      $display("[TB] FAIL err_restart: got err=%b rdy=%b hold=%b done=%b expected 0 1 1 0",
               err, in_ready, cpu_hold, done);
    end
  endtask

  task automatic test_random_valid();
    startTest();
    strm = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00,
             8'h93, 8'h01, 8'h00, 8'h00};
    buildExpected();
    sendStream(50);
    repeat (2) @(negedge clk);
    nCompared++;
    if ({done, cpu_hold} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL gaps_done: got done=%b hold=%b expected 1 0", done, cpu_hold);
    end
    nCompared++;
    if (actQ.size() != expQ.size()) begin
      nMismatched++;
      $display("[TB] FAIL gaps_nwrites: got %0d expected %0d", actQ.size(), expQ.size());
    end
    foreach (expQ[i]) if (i < actQ.size()) begin
      nCompared++;
      if (actQ[i] !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL gaps_write%0d: got %h expected %h", i, actQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_abort();
    startTest();
    strm = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    buildExpected();
    sendStream(100);
    // restart with a byte offered in the same cycle; that byte must be dropped
    @(negedge clk);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h55;
    @(negedge clk);
    load_start = 1'b0;
    in_valid   = 1'b0;
    nCompared++;
    if ({cpu_hold, in_ready, done} !== 3'b110) begin
      nMismatched++;
      $display("[TB] FAIL abort_state: got hold=%b rdy=%b done=%b expected 1 1 0", cpu_hold, in_ready, done);
    end
    strm = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    buildExpected();
    sendStream(100);
    repeat (2) @(negedge clk);
    nCompared++;
    if ({done, cpu_hold} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL abort_done: got done=%b hold=%b expected 1 0", done, cpu_hold);
    end
    nCompared++;
    if (actQ.size() != 2 || actQ[1] !== {8'h00, 32'hDEADBEEF}) begin
      nMismatched++;
      $display("[TB] FAIL abort_final: got %0d writes last %h expected 2 writes last 00deadbeef",
               actQ.size(), (actQ.size() > 0) ? actQ[actQ.size()-1] : wr_t'(0));
    end
    foreach (expQ[i]) if (i < actQ.size()) begin
      nCompared++;
      if (actQ[i] !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL abort_write%0d: got %h expected %h", i, actQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_random_images();
    for (int t = 0; t < 4; t++) begin
      int cnt;
      int pct;
      startTest();
      cnt  = int'($urandom_range(12, 1));
      pct  = int'($urandom_range(100, 30));
      strm = '{8'(cnt), 8'h00};
      repeat (4 * cnt) strm.push_back(8'($urandom));
      buildExpected();
      sendStream(pct);
      repeat (2) @(negedge clk);
      nCompared++;
      if ({done, cpu_hold, in_ready} !== 3'b100) begin
        nMismatched++;
        $display("[TB] FAIL rand%0d_done: got done=%b hold=%b rdy=%b expected 1 0 0", t, done, cpu_hold, in_ready);
      end
      nCompared++;
      if (actQ.size() != expQ.size()) begin
        nMismatched++;
        $display("[TB] FAIL rand%0d_nwrites: got %0d expected %0d", t, actQ.size(), expQ.size());
      end
      foreach (expQ[i]) if (i < actQ.size()) begin
        nCompared++;
        if (actQ[i] !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL rand%0d_write%0d: got %h expected %h", t, i, actQ[i], expQ[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_and_full();
    startTest();
    strm = '{8'h03, 8'h00};
    repeat (4) strm.push_back(8'($urandom));
    buildExpected();
    repeat (4) strm.push_back(8'($urandom));
    sendStream(100);
    // second word's write is pending in this cycle; reset must suppress it
    #2 rst_n = 1'b0;
    #1;
    nCompared++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err} !==
        {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL midreset_values: got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b expected 0 0 00 0 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nCompared++;
    if (actQ.size() != 1 || (actQ.size() == 1 && actQ[0] !== expQ[0])) begin
      nMismatched++;
      $display("[TB] FAIL midreset_writes: got %0d writes expected 1 write %h", actQ.size(), expQ[0]);
    end
    actQ.delete();
    expQ.delete();
    strm = '{8'h00, 8'h01};
    repeat (4 * DEPTH) strm.push_back(8'($urandom));
    buildExpected();
    sendStream(100);
    repeat (4) @(negedge clk);
    nCompared++;
    if ({done, cpu_hold, in_ready, mem_addr} !== {3'b100, 8'hFF}) begin
      nMismatched++;
      $display("[TB] FAIL full_done: got done=%b hold=%b rdy=%b a=%h expected 1 0 0 ff",
               done, cpu_hold, in_ready, mem_addr);
    end
    nCompared++;
    if (actQ.size() != DEPTH) begin
      nMismatched++;
      $display("[TB] FAIL full_nwrites: got %0d expected %0d", actQ.size(), DEPTH);
    end
    foreach (expQ[i]) if (i < actQ.size()) begin
      nCompared++;
      if (actQ[i] !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL full_write%0d: got %h expected %h", i, actQ[i], expQ[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_err();
    test_random_valid();
    test_abort();
    test_random_images();
    test_reset_mid_and_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
